// File: rtl/issue_dual_queue_if.sv
// Decode <-> issue-queue <-> issue-stage handshake bundle.
// master: decode/issue side (drives decoded sets, flush, stalls).
// slave : the issue queue itself.
interface issue_dual_queue_if;
  typedef struct packed {
    logic [31:0] pc;
    logic [9:0]  inst_type;   // 10'h001 = simple ALU op
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [2:0]  br_type;     // nonzero = branch
    logic        o_valid;
  } pc_set_t;

  pc_set_t d_set1, d_set2, i_set1, i_set2;
  logic    buffer_full, flush_BR, stall_DCache, stall_div;

  modport master (output d_set1, d_set2, flush_BR, stall_DCache, stall_div,
                  input  buffer_full, i_set1, i_set2);
  modport slave  (input  d_set1, d_set2, flush_BR, stall_DCache, stall_div,
                  output buffer_full, i_set1, i_set2);
endinterface

// File: rtl/issue_dual_queue.sv
// Dual-push / dual-pop circular instruction buffer between decode and issue.
// Head pair is checked against the dual-issue pairing rules each cycle.
// Optional: define ISSUE_PERF_CNT_EN to add issue/dual/full perf counters.
module issue_dual_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  issue_dual_queue_if.slave    bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_issue_cycles,
  output logic [31:0]          perf_dual_cycles,
  output logic [31:0]          perf_full_cycles
`endif
);
  localparam int CNT_W = PTR_W + 1;

  // Same layout as the interface struct, so plain assignment converts.
  typedef struct packed {
    logic [31:0] pc;
    logic [9:0]  inst_type;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [2:0]  br_type;
    logic        o_valid;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t             d1, d2, h1, h2, o1, o2;
  logic               full, stall, flush, v1, v2, pair_ok;
  logic [CNT_W-1:0]   n_push, n_pop;

  assign d1    = bus.d_set1;
  assign d2    = bus.d_set2;
  assign flush = bus.flush_BR;
  assign stall = bus.stall_DCache | bus.stall_div;

  assign bus.i_set1      = o1;
  assign bus.i_set2      = o2;
  assign bus.buffer_full = full;

  // Head pair, pairing rules, push/pop amounts and next-state pointers.
  always_comb begin
    h1 = mem_q[rd_ptr_q];
    h2 = mem_q[rd_ptr_q + PTR_W'(1)];
    // Only pipe B takes non-ALU ops; RAW/WAW within the pair; branch issues alone.
    pair_ok = (h1.inst_type == 10'h001 || h2.inst_type == 10'h001)
           && !(h1.rf_we && h1.rf_rd != 5'd0 &&
                (h1.rf_rd == h2.rf_raddr1 || h1.rf_rd == h2.rf_raddr2))
           && !(h1.rf_we && h2.rf_we && h1.rf_rd != 5'd0 && h1.rf_rd == h2.rf_rd)
           && (h1.br_type == 3'd0);
    full = count_q > CNT_W'(DEPTH - 2);
    v1   = (count_q != '0) && !flush;
    v2   = v1 && (count_q >= CNT_W'(2)) && pair_ok;
    o1   = h1;
    o1.o_valid = v1;
    o2   = h2;
    o2.o_valid = v2;

    // Flush already zeroes v1/v2, so only stall gates the pop.
    n_pop = stall ? '0 : (CNT_W'(v1) + CNT_W'(v2));

    // A lone valid set (either slot) is compacted into wr_ptr.
    mem_d  = mem_q;
    n_push = '0;
    if (!full && !flush) begin
      if (d1.o_valid && d2.o_valid) begin
        mem_d[wr_ptr_q]              = d1;
        mem_d[wr_ptr_q + PTR_W'(1)]  = d2;
        n_push = CNT_W'(2);
      end else if (d1.o_valid) begin
        mem_d[wr_ptr_q] = d1;
        n_push = CNT_W'(1);
      end else if (d2.o_valid) begin
        mem_d[wr_ptr_q] = d2;
        n_push = CNT_W'(1);
      end
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PTR_W'(n_pop);
    count_d  = flush ? '0 : count_q + n_push - n_pop;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issue_q, issue_d, dual_q, dual_d, fullc_q, fullc_d;

  // Perf counters; free-running, wrap at 2^32.
  always_comb begin
    issue_d = issue_q + ((!stall && v1) ? 32'd1 : 32'd0);
    dual_d  = dual_q  + ((!stall && v2) ? 32'd1 : 32'd0);
    fullc_d = fullc_q + (full ? 32'd1 : 32'd0);
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_q <= '0;
      dual_q  <= '0;
      fullc_q <= '0;
    end else begin
      issue_q <= issue_d;
      dual_q  <= dual_d;
      fullc_q <= fullc_d;
    end
  end

  assign perf_issue_cycles = issue_q;
  assign perf_dual_cycles  = dual_q;
  assign perf_full_cycles  = fullc_q;
`endif

endmodule

// File: tb/tb_issue_dual_queue.sv
// Bench for issue_dual_queue: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_issue_dual_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [9:0]  inst_type;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [2:0]  br_type;
    logic        o_valid;
  } pc_set_t;

  logic clk, rstn;
  int   checks, failures;
  pc_set_t mq[$];

  issue_dual_queue_if bus ();

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issue_cycles, perf_dual_cycles, perf_full_cycles;
`endif

  issue_dual_queue #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_issue_cycles (perf_issue_cycles),
    .perf_dual_cycles  (perf_dual_cycles),
    .perf_full_cycles  (perf_full_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pc_set_t mk(input logic [31:0] pc, input logic [9:0] ty,
                                 input logic we, input logic [4:0] rd,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
    pc_set_t s;
    s.pc = pc; s.inst_type = ty; s.rf_we = we; s.rf_rd = rd;
    s.rf_raddr1 = ra1; s.rf_raddr2 = ra2; s.br_type = 3'd0; s.o_valid = 1'b1;
    return s;
  endfunction

  task automatic drive(input pc_set_t a, input pc_set_t b, input logic fl, input logic st);
    bus.d_set1 = a; bus.d_set2 = b; bus.flush_BR = fl;
    bus.stall_div = st; bus.stall_DCache = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    #3;
    checks++; if (bus.buffer_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.buffer_full); end
    checks++; if (bus.i_set1.o_valid !== 1'b0) begin failures++; $display("FAIL reset_v1 got=%b exp=0", bus.i_set1.o_valid); end
    checks++; if (bus.i_set2.o_valid !== 1'b0) begin failures++; $display("FAIL reset_v2 got=%b exp=0", bus.i_set2.o_valid); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_dual_alu();
    drive(mk(32'h100, 10'h001, 1'b1, 5'd1, 5'd0, 5'd0), mk(32'h104, 10'h001, 1'b1, 5'd2, 5'd0, 5'd0), 1'b0, 1'b0);
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b0) begin failures++; $display("FAIL dual_empty_v1 got=%b exp=0", bus.i_set1.o_valid); end
    tick();
    drive('0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b1) begin failures++; $display("FAIL dual_v1 got=%b exp=1", bus.i_set1.o_valid); end
    checks++; if (bus.i_set2.o_valid !== 1'b1) begin failures++; $display("FAIL dual_v2 got=%b exp=1", bus.i_set2.o_valid); end
    checks++; if (bus.i_set1.pc !== 32'h100) begin failures++; $display("FAIL dual_pc1 got=%h exp=100", bus.i_set1.pc); end
    checks++; if (bus.i_set2.pc !== 32'h104) begin failures++; $display("FAIL dual_pc2 got=%h exp=104", bus.i_set2.pc); end
    tick();
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b0) begin failures++; $display("FAIL dual_drained got=%b exp=0", bus.i_set1.o_valid); end
    tick();
  endtask

  task automatic test_raw();
    drive(mk(32'h200, 10'h001, 1'b1, 5'd5, 5'd0, 5'd0), mk(32'h204, 10'h001, 1'b1, 5'd6, 5'd5, 5'd0), 1'b0, 1'b0);
    tick();
    drive('0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b1 || bus.i_set1.pc !== 32'h200) begin failures++; $display("FAIL raw_c1_head got=%b/%h exp=1/200", bus.i_set1.o_valid, bus.i_set1.pc); end
    checks++; if (bus.i_set2.o_valid !== 1'b0) begin failures++; $display("FAIL raw_c1_v2 got=%b exp=0", bus.i_set2.o_valid); end
    tick();
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b1 || bus.i_set1.pc !== 32'h204) begin failures++; $display("FAIL raw_c2_head got=%b/%h exp=1/204", bus.i_set1.o_valid, bus.i_set1.pc); end
    checks++; if (bus.i_set2.o_valid !== 1'b0) begin failures++; $display("FAIL raw_c2_v2 got=%b exp=0", bus.i_set2.o_valid); end
    tick();
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b0) begin failures++; $display("FAIL raw_drained got=%b exp=0", bus.i_set1.o_valid); end
  endtask

  // Non-ALU ops never pair, so each pop removes exactly one entry.
  task automatic test_full();
    for (int i = 0; i < 3; i++) begin
      drive(mk(32'h300 + 8*i, 10'h002, 1'b0, 5'd0, 5'd0, 5'd0),
            mk(32'h304 + 8*i, 10'h002, 1'b0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b1);
      tick();
    end
    drive(mk(32'h318, 10'h002, 1'b0, 5'd0, 5'd0, 5'd0), '0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.buffer_full !== 1'b0) begin failures++; $display("FAIL full_at6 got=%b exp=0", bus.buffer_full); end
    tick();
    drive(mk(32'h400, 10'h002, 1'b0, 5'd0, 5'd0, 5'd0), mk(32'h404, 10'h002, 1'b0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b1);
    #1;
    checks++; if (bus.buffer_full !== 1'b1) begin failures++; $display("FAIL full_at7 got=%b exp=1", bus.buffer_full); end
    checks++; if (bus.i_set1.pc !== 32'h300 || bus.i_set2.o_valid !== 1'b0) begin failures++; $display("FAIL full_head got=%h/%b exp=300/0", bus.i_set1.pc, bus.i_set2.o_valid); end
    tick();
    drive('0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.buffer_full !== 1'b1) begin failures++; $display("FAIL full_push_ignored got=%b exp=1", bus.buffer_full); end
    tick();
    drive('0, '0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.buffer_full !== 1'b0) begin failures++; $display("FAIL full_after_pop got=%b exp=0", bus.buffer_full); end
    checks++; if (bus.i_set1.pc !== 32'h304) begin failures++; $display("FAIL full_next_head got=%h exp=304", bus.i_set1.pc); end
    // Drain with a flush so the next test starts empty.
    drive('0, '0, 1'b1, 1'b0);
    tick();
    drive('0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b0) begin failures++; $display("FAIL full_flushed got=%b exp=0", bus.i_set1.o_valid); end
  endtask

  task automatic test_stall();
    drive(mk(32'h500, 10'h001, 1'b1, 5'd1, 5'd0, 5'd0), mk(32'h504, 10'h001, 1'b1, 5'd2, 5'd0, 5'd0), 1'b0, 1'b1);
    tick();
    drive(mk(32'h508, 10'h001, 1'b1, 5'd3, 5'd0, 5'd0), mk(32'h50c, 10'h001, 1'b1, 5'd4, 5'd0, 5'd0), 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(mk(32'h510, 10'h001, 1'b1, 5'd7, 5'd0, 5'd0), mk(32'h514, 10'h001, 1'b1, 5'd8, 5'd0, 5'd0), 1'b0, 1'b1);
      else if (c == 2) drive(mk(32'h518, 10'h001, 1'b1, 5'd9, 5'd0, 5'd0), '0, 1'b0, 1'b1);
      else drive('0, '0, 1'b0, 1'b1);
      #1;
      checks++; if (bus.i_set1.pc !== 32'h500 || bus.i_set1.o_valid !== 1'b1) begin failures++; $display("FAIL stall_pc1 cyc=%0d got=%h/%b exp=500/1", c, bus.i_set1.pc, bus.i_set1.o_valid); end
      checks++; if (bus.i_set2.pc !== 32'h504 || bus.i_set2.o_valid !== 1'b1) begin failures++; $display("FAIL stall_pc2 cyc=%0d got=%h/%b exp=504/1", c, bus.i_set2.pc, bus.i_set2.o_valid); end
      checks++; if (bus.buffer_full !== 1'b0) begin failures++; $display("FAIL stall_full cyc=%0d got=%b exp=0", c, bus.buffer_full); end
      tick();
    end
    drive('0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.buffer_full !== 1'b1) begin failures++; $display("FAIL stall_count7 got=%b exp=1", bus.buffer_full); end
    tick();
    #1;
    checks++; if (bus.buffer_full !== 1'b0) begin failures++; $display("FAIL stall_after_pop got=%b exp=0", bus.buffer_full); end
    checks++; if (bus.i_set1.pc !== 32'h508 || bus.i_set2.pc !== 32'h50c) begin failures++; $display("FAIL stall_resume got=%h/%h exp=508/50c", bus.i_set1.pc, bus.i_set2.pc); end
  endtask

  // Five entries queued here, plus a valid push in the flush cycle.
  task automatic test_flush();
    drive(mk(32'h600, 10'h001, 1'b1, 5'd1, 5'd0, 5'd0), '0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b0) begin failures++; $display("FAIL flush_v1 got=%b exp=0", bus.i_set1.o_valid); end
    checks++; if (bus.i_set2.o_valid !== 1'b0) begin failures++; $display("FAIL flush_v2 got=%b exp=0", bus.i_set2.o_valid); end
    tick();
    drive('0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b0) begin failures++; $display("FAIL flush_next_v1 got=%b exp=0", bus.i_set1.o_valid); end
    checks++; if (bus.buffer_full !== 1'b0) begin failures++; $display("FAIL flush_next_full got=%b exp=0", bus.buffer_full); end
    tick();
  endtask

  function automatic pc_set_t rnd_set(input logic [31:0] pc);
    pc_set_t s;
    s.pc        = pc;
    s.inst_type = ($urandom_range(0, 3) == 0) ? 10'h002 : 10'h001;
    s.rf_we     = 1'($urandom_range(0, 1));
    s.rf_rd     = 5'($urandom_range(0, 3));
    s.rf_raddr1 = 5'($urandom_range(0, 3));
    s.rf_raddr2 = 5'($urandom_range(0, 3));
    s.br_type   = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
    s.o_valid   = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  // Dual-issue legality of an (older, younger) pair.
  function automatic bit can_pair(input pc_set_t a, input pc_set_t b);
    bit alu_ok, raw, waw;
    alu_ok = (a.inst_type == 10'h001) || (b.inst_type == 10'h001);
    raw    = a.rf_we && a.rf_rd != 0 && (a.rf_rd == b.rf_raddr1 || a.rf_rd == b.rf_raddr2);
    waw    = a.rf_we && b.rf_we && a.rf_rd != 0 && a.rf_rd == b.rf_rd;
    return alu_ok && !raw && !waw && a.br_type == 0;
  endfunction

  task automatic test_random();
    logic [31:0] pc = 32'h1000;
    pc_set_t a, b;
    bit fl, st, e_full, e_v1, e_v2;
    mq.delete();
    for (int n = 0; n < 400; n++) begin
      a = rnd_set(pc); b = rnd_set(pc + 4); pc += 8;
      fl = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 3) == 0);
      bus.d_set1 = a; bus.d_set2 = b; bus.flush_BR = fl;
      bus.stall_div = st && $urandom_range(0, 1) == 0;
      bus.stall_DCache = st && !bus.stall_div;
      #1;
      e_full = mq.size() > DEPTH - 2;
      e_v1   = mq.size() >= 1 && !fl;
      e_v2   = 1'b0;
      if (e_v1 && mq.size() >= 2) e_v2 = can_pair(mq[0], mq[1]);
      checks++; if (bus.buffer_full !== e_full) begin failures++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, bus.buffer_full, e_full); end
      checks++; if (bus.i_set1.o_valid !== e_v1) begin failures++; $display("FAIL rnd_v1 n=%0d got=%b exp=%b", n, bus.i_set1.o_valid, e_v1); end
      checks++; if (bus.i_set2.o_valid !== e_v2) begin failures++; $display("FAIL rnd_v2 n=%0d got=%b exp=%b", n, bus.i_set2.o_valid, e_v2); end
      if (e_v1) begin
        checks++; if (bus.i_set1.pc !== mq[0].pc) begin failures++; $display("FAIL rnd_pc1 n=%0d got=%h exp=%h", n, bus.i_set1.pc, mq[0].pc); end
      end
      if (e_v2) begin
        checks++; if (bus.i_set2.pc !== mq[1].pc) begin failures++; $display("FAIL rnd_pc2 n=%0d got=%h exp=%h", n, bus.i_set2.pc, mq[1].pc); end
      end
      if (fl) mq.delete();
      else begin
        if (!st) begin
          if (e_v1) void'(mq.pop_front());
          if (e_v2) void'(mq.pop_front());
        end
        if (!e_full) begin
          if (a.o_valid) mq.push_back(a);
          if (b.o_valid) mq.push_back(b);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive('0, '0, 1'b1, 1'b0);
    tick();
    drive(mk(32'h700, 10'h001, 1'b1, 5'd1, 5'd0, 5'd0), mk(32'h704, 10'h001, 1'b1, 5'd2, 5'd0, 5'd0), 1'b0, 1'b1);
    tick();
    drive('0, '0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", bus.i_set1.o_valid); end
    rstn = 1'b0;
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b0 || bus.i_set2.o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b/%b exp=0/0", bus.i_set1.o_valid, bus.i_set2.o_valid); end
    tick();
    rstn = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    tick();
    #1;
    checks++; if (bus.i_set1.o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b exp=0", bus.i_set1.o_valid); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_dual_alu();
    test_raw();
    test_full();
    test_stall();
    test_flush();
    drive('0, '0, 1'b1, 1'b0);
    tick();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
